// File: rtl/pwm_rgb_pkg.sv
// pwm_rgb_pkg: register map, CTRL bit indices and fade FSM types for iomem_pwm_rgb
package pwm_rgb_pkg;
  localparam logic [7:0] PWM_CTRL        = 8'h00;
  localparam logic [7:0] PWM_PRESCALE    = 8'h04;
  localparam logic [7:0] PWM_DUTY        = 8'h08;
  localparam logic [7:0] PWM_FADE_TARGET = 8'h0C;
  localparam logic [7:0] PWM_FADE_RATE   = 8'h10;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_GO   = 1;
  localparam int CTRL_BUSY = 8;
  typedef enum logic [1:0] {IDLE, WAIT, STEP} fade_state_t;
  function automatic logic [7:0] step_toward(input logic [7:0] d, input logic [7:0] t);
    return d < t ? d + 8'd1 : d > t ? d - 8'd1 : d;
  endfunction
endpackage

// File: rtl/pwm_rgb_fade.sv
// pwm_rgb_fade: fade FSM stepping each duty channel by one toward its target every rate+1 periods
module pwm_rgb_fade
  import pwm_rgb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        go,
  input  logic        wrap,
  input  logic [15:0] rate,
  input  logic [23:0] duty,
  input  logic [23:0] target,
  output logic        busy,
  output logic        step,
  output logic [23:0] step_duty
);
  fade_state_t state;
  logic [15:0] rate_cnt;
  assign step = state == STEP;
  assign step_duty = {step_toward(duty[23:16], target[23:16]),
                      step_toward(duty[15:8], target[15:8]),
                      step_toward(duty[7:0], target[7:0])};
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rate_cnt <= '0;
      busy     <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (go) begin
      state    <= WAIT;
      rate_cnt <= rate;
      busy     <= 1'b1;
    end else begin
      case (state)
        WAIT: if (wrap) begin
          if (rate_cnt == '0) state <= STEP;
          else rate_cnt <= rate_cnt - 16'd1;
        end
        STEP: if (step_duty == target) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state    <= WAIT;
          rate_cnt <= rate;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/iomem_pwm_rgb.sv
// iomem_pwm_rgb: iomem-mapped 3-channel 8-bit PWM for the RGB LED.
// Define PWM_RGB_FADE_EN to build in the hardware fade engine.
module iomem_pwm_rgb
  import pwm_rgb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);
  logic        sel, wr, ctrl_wr, en, en_nxt, tick, busy, step, unused_ok;
  logic [7:0]  off, cnt, act_r, act_g, act_b;
  logic [15:0] prescale, pre;
  logic [23:0] duty, step_duty;
  logic [31:0] rd, fade_rd;
  assign sel     = iomem_valid && !iomem_ready && iomem_addr[31:8] == BASE_ADDR[31:8];
  assign off     = iomem_addr[7:0];
  assign wr      = sel && |iomem_wstrb;
  assign ctrl_wr = wr && off == PWM_CTRL && iomem_wstrb[0];
  assign en_nxt  = ctrl_wr ? iomem_wdata[CTRL_EN] : en;
  assign tick    = pre >= prescale;
  assign unused_ok = ^{iomem_wdata[31:24], iomem_wstrb[3]};
`ifdef PWM_RGB_FADE_EN
  logic [23:0] target;
  logic [15:0] rate;
  always_ff @(posedge clk) begin
    if (reset) begin
      target <= '0;
      rate   <= '0;
    end else if (wr) begin
      if (off == PWM_FADE_TARGET)
        for (int i = 0; i < 3; i++) if (iomem_wstrb[i]) target[8*i +: 8] <= iomem_wdata[8*i +: 8];
      if (off == PWM_FADE_RATE)
        for (int i = 0; i < 2; i++) if (iomem_wstrb[i]) rate[8*i +: 8] <= iomem_wdata[8*i +: 8];
    end
  end
  assign fade_rd = off == PWM_FADE_TARGET ? {8'h0, target} :
                   off == PWM_FADE_RATE   ? {16'h0, rate} : '0;
  pwm_rgb_fade u_fade (
    .clk      (clk),
    .reset    (reset),
    .en       (en_nxt),
    .go       (ctrl_wr && iomem_wdata[CTRL_GO] && iomem_wdata[CTRL_EN]),
    .wrap     (en && tick && cnt == 8'hFF),
    .rate     (rate),
    .duty     (duty),
    .target   (target),
    .busy     (busy),
    .step     (step),
    .step_duty(step_duty)
  );
`else
  assign fade_rd   = '0;
  assign busy      = 1'b0;
  assign step      = 1'b0;
  assign step_duty = duty;
`endif
  assign rd = off == PWM_CTRL     ? 32'(busy) << CTRL_BUSY | 32'(en) :
              off == PWM_PRESCALE ? {16'h0, prescale} :
              off == PWM_DUTY     ? {8'h0, duty} : fade_rd;
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      en          <= 1'b0;
      prescale    <= '0;
      duty        <= '0;
      pre         <= '0;
      cnt         <= '0;
      {act_b, act_g, act_r} <= '0;
      {led_r, led_g, led_b} <= '0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rd : '0;
      en          <= en_nxt;
      if (step) duty <= step_duty;
      if (wr && off == PWM_PRESCALE)
        for (int i = 0; i < 2; i++) if (iomem_wstrb[i]) prescale[8*i +: 8] <= iomem_wdata[8*i +: 8];
      if (wr && off == PWM_DUTY)
        for (int i = 0; i < 3; i++) if (iomem_wstrb[i]) duty[8*i +: 8] <= iomem_wdata[8*i +: 8];
      if (!en) begin
        pre <= '0;
        cnt <= '0;
      end else if (tick) begin
        pre <= '0;
        cnt <= cnt + 8'd1;
      end else pre <= pre + 16'd1;
      // active duty only changes at the period boundary (or while idle) to keep edges glitch-free
      if (!en || (tick && cnt == 8'hFF)) {act_b, act_g, act_r} <= duty;
      led_r <= en && cnt < act_r;
      led_g <= en && cnt < act_g;
      led_b <= en && cnt < act_b;
    end
  end
endmodule

// File: tb/tb_iomem_pwm_rgb.sv
// tb_iomem_pwm_rgb: directed bus and PWM waveform checks for iomem_pwm_rgb
module tb_iomem_pwm_rgb;
  localparam logic [31:0] B = 32'h0300_0100;
  logic clk = 0, reset = 1, iomem_valid = 0, iomem_ready, led_r, led_g, led_b;
  logic [3:0] iomem_wstrb = 0;
  logic [31:0] iomem_addr = 0, iomem_wdata = 0, iomem_rdata;
  int checks = 0, errors = 0;
  int acc_r = 0, acc_g = 0, acc_b = 0, last_r = 0, last_g = 0, last_b = 0, periods = 0;
  logic g_q = 0;
  logic [31:0] r;
  int lat;

  always #5 clk = ~clk;

  iomem_pwm_rgb dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  // a falling edge of led_g (G duty 255) closes one PWM period of high-time counts
  always @(negedge clk) begin
    if (g_q && !led_g) begin
      last_r = acc_r + int'(led_r);
      last_g = acc_g;
      last_b = acc_b + int'(led_b);
      acc_r = 0; acc_g = 0; acc_b = 0;
      periods++;
    end else begin
      acc_r += int'(led_r);
      acc_g += int'(led_g);
      acc_b += int'(led_b);
    end
    g_q = led_g;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rdat, output int l);
    @(posedge clk); #1;
    iomem_valid = 1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    l = 0; rdat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin
        l = i; rdat = iomem_rdata;
        break;
      end
    end
    iomem_valid = 0; iomem_wstrb = 0;
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] x;
    int l;
    bus(B + 32'(o), d, s, x, l);
    check("wr_ack", l, 1);
  endtask

  task automatic rd(input logic [7:0] o, output logic [31:0] d);
    int l;
    bus(B + 32'(o), 32'hDEAD_BEEF, 4'b0000, d, l);
    check("rd_ack", l, 1);
  endtask

  task automatic wait_period();
    int n0 = periods;
    bit done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      @(posedge clk);
      if (periods != n0) done = 1;
    end
    if (!done) check("period_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", iomem_ready, 0);
    check("rst_rdata", iomem_rdata, 0);
    check("rst_leds", {led_r, led_g, led_b}, 0);
    reset = 0;
    rd(8'h00, r); check("rst_ctrl", r, 0);
    rd(8'h08, r); check("rst_duty", r, 0);
    @(posedge clk); #1;
    check("ready_pulse", iomem_ready, 0);
    check("rdata_idle", iomem_rdata, 0);

    wr(8'h04, 32'h0001_2345, 4'b1111);
    rd(8'h04, r); check("prescale_rb", r, 32'h2345);
    wr(8'h04, 0, 4'b1111);

    wr(8'h08, 32'h00FF40, 4'b1111);
    wr(8'h00, 1, 4'b0001);
    rd(8'h00, r); check("ctrl_en", r, 1);
    wait_period(); wait_period();
    check("duty_r64", last_r, 64);
    check("duty_g255", last_g, 255);
    check("duty_b0", last_b, 0);

    wait_period();
    repeat (99) @(posedge clk);
    wr(8'h08, 32'h80, 4'b0001);
    wait_period(); check("mid_cur_r", last_r, 64);
    wait_period(); check("mid_next_r", last_r, 128);

    wr(8'h04, 1, 4'b0011);
    wait_period(); wait_period();
    check("pre1_r", last_r, 256);
    check("pre1_g", last_g, 510);
    check("pre1_b", last_b, 0);
    wr(8'h04, 0, 4'b0011);

    wr(8'h08, 32'h005500, 4'b0010);
    rd(8'h08, r); check("strobe_g", r, 32'h005580);

    wr(8'h00, 0, 4'b0001);
    repeat (2) @(posedge clk);
    #1 check("dis_leds", {led_r, led_g, led_b}, 0);

`ifdef PWM_RGB_FADE_EN
    begin
      logic [31:0] prev;
      wr(8'h08, 0, 4'b1111);
      wr(8'h0C, 3, 4'b1111);
      wr(8'h10, 0, 4'b1111);
      rd(8'h0C, r); check("target_rb", r, 3);
      wr(8'h00, 3, 4'b0001);
      rd(8'h00, r); check("fade_busy", r, 32'h101);
      prev = 0;
      for (int v = 1; v <= 3; v++) begin
        for (int i = 0; i < 400; i++) begin
          rd(8'h08, r);
          if (r != prev) break;
        end
        check("fade_r", r, 32'(v));
        prev = r;
      end
      rd(8'h00, r); check("fade_done", r, 1);
      wr(8'h0C, 32'h20, 4'b1111);
      wr(8'h00, 3, 4'b0001);
      rd(8'h00, r); check("abort_busy", r, 32'h101);
      wr(8'h00, 0, 4'b0001);
      rd(8'h00, r); check("abort_ctrl", r, 0);
      #1 check("abort_leds", {led_r, led_g, led_b}, 0);
    end
`else
    wr(8'h0C, 32'h030303, 4'b1111);
    rd(8'h0C, r); check("no_target", r, 0);
    wr(8'h10, 5, 4'b1111);
    rd(8'h10, r); check("no_rate", r, 0);
    wr(8'h00, 3, 4'b0001);
    rd(8'h00, r); check("no_busy", r, 1);
    wr(8'h00, 0, 4'b0001);
`endif

    rd(8'h20, r); check("unmapped_rd", r, 0);
    bus(32'h0300_0000, 0, 4'b0000, r, lat);
    check("oow_ack", lat, 0);

    wr(8'h08, 32'h112233, 4'b1111);
    wr(8'h00, 1, 4'b0001);
    repeat (5) @(posedge clk);
    #1;
    iomem_valid = 1; iomem_addr = B + 8; iomem_wstrb = 0; reset = 1;
    @(posedge clk); #1;
    check("rst_mid_ready", iomem_ready, 0);
    iomem_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    check("rst_mid_leds", {led_r, led_g, led_b}, 0);
    rd(8'h08, r); check("rst_mid_duty", r, 0);
    rd(8'h00, r); check("rst_mid_ctrl", r, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
